vbs_timing_gen: RTL and testbench

Parametrised composite-video (VBS) timing generator and pixel serialiser. It is the successor to the fixed-mode video generator that drives `videoSync`/`videoPixel`. Line/frame geometry, fetch latency and active window are generic. It issues pipelined `x`/`y` fetch requests to a video RAM, accepts returned pixel data a fixed latency later, and emits a broad-pulse vertical sync, a frame strobe and an optional serrated vertical sync.

---
 rtl/vbs_timing_gen_if.sv | 27 ++
 rtl/vbs_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vbs_timing_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vbs_timing_gen_if.sv
// Video timing bus: RAM fetch request/return plus composite video outputs.
interface vbs_timing_gen_if #(
    parameter int unsigned X_BITS = 9,
    parameter int unsigned Y_BITS = 8
);
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic              valid;
    logic              data;
    logic              invert;
    logic              visible;
    logic              sync;
    logic              pixel;
    logic              frame;

    // Generator side: drives requests and video, receives RAM data and polarity.
    modport master (
        output x, y, valid, visible, sync, pixel, frame,
        input  data, invert
    );

    // Consumer side: RAM model / video sink.
    modport slave (
        input  x, y, valid, visible, sync, pixel, frame,
        output data, invert
    );
endinterface

// File: rtl/vbs_timing_gen.sv
// Composite-video (VBS) timing generator and pixel serialiser.
// Issues pipelined x/y fetch requests LEAD+1 clocks ahead of the pixel they
// produce, and emits composite sync, frame strobe and visible flag.
// Optional build macro: VBS_SERRATION_EN splits each vsync line into two
// serrated half-lines; when undefined each vsync line is one broad pulse.
module vbs_timing_gen #(
    parameter int unsigned H_TOTAL  = 384,
    parameter int unsigned H_SYNC   = 28,
    parameter int unsigned H_START  = 80,
    parameter int unsigned H_WIDTH  = 256,
    parameter int unsigned V_TOTAL  = 312,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_START  = 50,
    parameter int unsigned V_HEIGHT = 200,
    parameter int unsigned LEAD     = 2,
    parameter int unsigned X_BITS   = 9,
    parameter int unsigned Y_BITS   = 8
) (
    input  logic              clk,
    input  logic              resetN,
    vbs_timing_gen_if.master  bus
);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);
    // Request column that lines up with the first visible pixel.
    localparam int unsigned R  = H_START - LEAD - 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNCW = HW'(H_SYNC);
    localparam logic [HW-1:0] REQ_LO  = HW'(R);
    localparam logic [HW-1:0] REQ_HI  = HW'(R + H_WIDTH - 1);
    localparam logic [HW-1:0] PIX_LO  = HW'(H_START);
    localparam logic [HW-1:0] PIX_HI  = HW'(H_START + H_WIDTH - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNCL = VW'(V_SYNC);
    localparam logic [VW-1:0] V_LO    = VW'(V_START);
    localparam logic [VW-1:0] V_HI    = VW'(V_START + V_HEIGHT - 1);
`ifdef VBS_SERRATION_EN
    localparam logic [HW-1:0] H_HALF  = HW'(H_TOTAL / 2);
    localparam logic [HW-1:0] H_SERR  = HW'(H_TOTAL / 2 - H_SYNC);
`else
    localparam logic [HW-1:0] H_BROAD = HW'(H_TOTAL - H_SYNC);
`endif

    // Reject geometries that cannot be generated.
    if (!(H_SYNC < R) ||
        !(H_START + H_WIDTH <= H_TOTAL) ||
        !(V_SYNC < V_START) ||
        !(V_START + V_HEIGHT <= V_TOTAL) ||
        !(longint'(H_WIDTH) <= (longint'(1) << X_BITS)) ||
        !(longint'(V_HEIGHT) <= (longint'(1) << Y_BITS)) ||
        !(LEAD >= 1)) begin : g_bad_cfg
        $error("vbs_timing_gen: inconsistent timing parameters");
    end
`ifdef VBS_SERRATION_EN
    if ((H_TOTAL % 2) != 0) begin : g_bad_half
        $error("vbs_timing_gen: H_TOTAL must be even for serration");
    end
`endif

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic              valid_q, valid_d;
    logic              visible_q, visible_d;
    logic              sync_q, sync_d;
    logic              pixel_q, pixel_d;
    logic              frame_q, frame_d;

    logic              in_vwin;
    logic              vs_sync;
`ifdef VBS_SERRATION_EN
    logic [HW-1:0]     h_half;
`endif

    // Next-state: raster counters and registered outputs for the current column.
    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        x_d       = x_q;
        y_d       = y_q;
        valid_d   = 1'b0;
        visible_d = 1'b0;
        pixel_d   = 1'b0;
        sync_d    = 1'b1;
        frame_d   = 1'b0;
        in_vwin   = 1'b0;
        vs_sync   = 1'b1;
`ifdef VBS_SERRATION_EN
        h_half    = '0;
`endif

        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end else begin
            h_d = h_q + HW'(1);
        end

`ifdef VBS_SERRATION_EN
        h_half  = (h_q >= H_HALF) ? h_q - H_HALF : h_q;
        vs_sync = (h_half >= H_SERR);
`else
        vs_sync = (h_q >= H_BROAD);
`endif
        sync_d = (v_q < V_SYNCL) ? vs_sync : (h_q >= H_SYNCW);

        in_vwin = (v_q >= V_LO) && (v_q <= V_HI);

        valid_d = in_vwin && (h_q >= REQ_LO) && (h_q <= REQ_HI);
        if (valid_d) begin
            x_d = X_BITS'(h_q - REQ_LO);
            y_d = Y_BITS'(v_q - V_LO);
        end

        // Gate data so pixel never depends on the RAM outside the window.
        visible_d = in_vwin && (h_q >= PIX_LO) && (h_q <= PIX_HI);
        pixel_d   = visible_d ? (bus.data ^ bus.invert) : 1'b0;

        frame_d = (h_q == '0) && (v_q == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_q       <= '0;
            v_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            visible_q <= 1'b0;
            sync_q    <= 1'b1;
            pixel_q   <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            visible_q <= visible_d;
            sync_q    <= sync_d;
            pixel_q   <= pixel_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.valid   = valid_q;
    assign bus.visible = visible_q;
    assign bus.sync    = sync_q;
    assign bus.pixel   = pixel_q;
    assign bus.frame   = frame_q;

endmodule

// File: tb/tb_vbs_timing_gen.sv
// Bench for vbs_timing_gen: per-clock scoreboard of all outputs plus
// directed sync-width, frame-period and post-reset latency checks.
module tb_vbs_timing_gen;

    localparam int VT    = 24;   // lines per frame in this bench
    localparam int VSL   = 10;   // first visible line
    localparam int VH    = 8;    // visible lines
    localparam int VSY   = 3;    // vsync lines
    localparam int FRAME = 384 * VT;
    localparam logic [21:0] RST_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0};
`ifdef VBS_SERRATION_EN
    localparam int VS_LOW = 2 * 164;
`else
    localparam int VS_LOW = 356;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic inv = 1'b0;

    vbs_timing_gen_if #(.X_BITS(9), .Y_BITS(8)) bus ();

    vbs_timing_gen #(
        .H_TOTAL(384), .H_SYNC(28), .H_START(80), .H_WIDTH(256),
        .V_TOTAL(VT), .V_SYNC(VSY), .V_START(VSL), .V_HEIGHT(VH),
        .LEAD(2), .X_BITS(9), .Y_BITS(8)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [21:0] outs;
    assign outs = {bus.frame, bus.sync, bus.pixel, bus.visible, bus.valid, bus.x, bus.y};

    // RAM model: returns x[0] of each request two clocks later, unknown otherwise.
    logic d1, d2, v1, v2;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            d1 <= 1'b0; d2 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
        end else begin
            d1 <= bus.x[0]; d2 <= d1;
            v1 <= bus.valid; v2 <= v1;
        end
    end
    assign bus.data   = !resetN ? 1'b1 : (v2 ? d2 : 1'bx);
    assign bus.invert = inv;

    // Reference raster: expected outputs pushed at each active edge.
    logic [21:0] sb[$];
    int mh = 0, mv = 0;
    logic [8:0] mx = '0;
    logic [7:0] my = '0;

    always @(negedge resetN) begin
        mh = 0; mv = 0; mx = '0; my = '0;
        sb.delete();
    end

    always @(posedge clk) begin
        if (resetN) begin
            logic ev, evis, epx, esync, efr;
            int c, l;
            c = mh; l = mv;
            ev = (l >= VSL) && (l < VSL + VH) && (c >= 77) && (c < 77 + 256);
            if (ev) begin
                mx = 9'(c - 77);
                my = 8'(l - VSL);
            end
            evis = (l >= VSL) && (l < VSL + VH) && (c >= 80) && (c < 80 + 256);
            epx  = evis ? ((((c - 80) % 2) == 1) ^ inv) : 1'b0;
            if (l < VSY) begin
`ifdef VBS_SERRATION_EN
                esync = ((c % 192) >= 164);
`else
                esync = (c >= 356);
`endif
            end else begin
                esync = (c >= 28);
            end
            efr = (c == 0) && (l == 0);
            sb.push_back({efr, esync, epx, evis, ev, mx, my});
            mh++;
            if (mh == 384) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (resetN) begin
            if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
            else                chk("outs", 32'(outs), 32'(sb.pop_front()));
        end
    end

    // Frame strobe period monitor.
    int fcyc = 0;
    bit fseen = 1'b0;
    always @(negedge resetN) fseen = 1'b0;
    always @(negedge clk) begin
        if (resetN) begin
            if (bus.frame) begin
                if (fseen) chk("frame_period", 32'(fcyc), 32'(FRAME));
                fseen = 1'b1;
                fcyc  = 1;
            end else begin
                fcyc++;
            end
        end
    end

    int k = -1;
    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    initial begin
        int n;
        int cnt;
        bit found;

        repeat (4) begin
            @(negedge clk);
            chk("rst_hold", 32'(outs), 32'(RST_VEC));
        end
        #2 resetN = 1'b1;

        for (int l = 0; l < VSY; l++) begin
            n = 0;
            for (int c = 0; c < 384; c++) begin
                tick();
                if (k == 0) chk("frame_first", 32'(bus.frame), 32'd1);
                if (!bus.sync) n++;
            end
            chk("vsync_low", 32'(n), 32'(VS_LOW));
        end

        while (k < 12 * 384 - 1) tick();
        n = 0;
        repeat (384) begin
            tick();
            if (!bus.sync) n++;
        end
        chk("hsync_low", 32'(n), 32'd28);

        while (k < FRAME - 1) tick();
        inv = 1'b1;

        while (k < 2 * FRAME + 15 * 384 + 200) tick();
        #2 resetN = 1'b0;
        #1 chk("rst_async", 32'(outs), 32'(RST_VEC));
        inv = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold2", 32'(outs), 32'(RST_VEC));
        end
        #2 resetN = 1'b1;

        cnt = 0;
        found = 1'b0;
        k = -1;
        while (!found && cnt < 20000) begin
            tick();
            if (bus.valid) found = 1'b1;
            else cnt++;
        end
        chk("first_valid", 32'(cnt), 32'(VSL * 384 + 77));

        while (k < FRAME + 400) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
